// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, FSM states, instruction field positions and flag indices
// Shared by instr_decoder and control_unit. No ports.
package cpu_pkg;

  // Opcode map: 0 JMP, 1-7 flag-setting ALU ops, 8 LD, 9 ST,
  // A ALU op without flags, B-E conditional branches, F CMP.
  localparam logic [3:0] OP_JMP       = 4'h0;
  localparam logic [3:0] OP_ALU_FIRST = 4'h1;
  localparam logic [3:0] OP_ALU_LAST  = 4'h7;
  localparam logic [3:0] OP_LD        = 4'h8;
  localparam logic [3:0] OP_ST        = 4'h9;
  localparam logic [3:0] OP_ALU_NF    = 4'hA;
  localparam logic [3:0] OP_BR_FIRST  = 4'hB;
  localparam logic [3:0] OP_BR_LAST   = 4'hE;
  localparam logic [3:0] OP_CMP       = 4'hF;

  // Instruction fields
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RA_MSB  = 8;
  localparam int RA_LSB  = 6;
  localparam int I_BIT   = 5;
  localparam int IMM_MSB = 4;
  localparam int RB_MSB  = 2;

  // Flag register bit indices
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_EXEC_WAIT,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_BRANCH,
    CLS_LD,
    CLS_ST,
    CLS_CMP
  } iclass_t;

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational instruction classification and immediate decode
// Ports:
//   opcode   in  4   ir[15:12]
//   i_bit    in  1   ir[5]
//   imm5     in  5   ir[4:0]
//   flag_en  out 1   ALU flag enable (opcodes 1-7)
//   flag_upd out 1   architectural flags take the ALU flags (opcodes 1-7, F)
//   wr_class out 1   instruction writes the register file (ALU ops and LD)
//   op1_imm  out 1   operand 1 is the immediate
//   imm      out 16  sign-extended imm5
//   iclass   out     instruction class
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic        i_bit,
  input  logic [4:0]  imm5,
  output logic        flag_en,
  output logic        flag_upd,
  output logic        wr_class,
  output logic        op1_imm,
  output logic [15:0] imm,
  output iclass_t     iclass
);

  always_comb begin
    flag_en  = (opcode >= OP_ALU_FIRST) && (opcode <= OP_ALU_LAST);
    flag_upd = flag_en || (opcode == OP_CMP);
    op1_imm  = i_bit;
    imm      = sext5(imm5);

    iclass = CLS_ALU;
    if (opcode == OP_JMP || (opcode >= OP_BR_FIRST && opcode <= OP_BR_LAST))
      iclass = CLS_BRANCH;
    else if (opcode == OP_LD)
      iclass = CLS_LD;
    else if (opcode == OP_ST)
      iclass = CLS_ST;
    else if (opcode == OP_CMP)
      iclass = CLS_CMP;

    // OP_ALU_NF falls into CLS_ALU above: it writes back but leaves flags alone.
    wr_class = (iclass == CLS_ALU) || (iclass == CLS_LD);
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle fetch/decode/execute sequencer in front of the ALU
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mem_addr/req/we/ack/rdata    request/acknowledge memory port (fetch and LD/ST)
//   alu_func/flag_en/b_sel/flags controls and latched NZVC to the ALU
//   alu_q/flag_q/b_out           ALU result, flags and branch-taken
//   rf_ra/rb/wa/we/wsrc          register-file selects and write strobe
//   op1_imm, imm                 operand-1 source select and sign-extended immediate
//   pc, ir                       program counter and instruction register
//   ld_data                      load data register, selected by rf_wsrc = 1
module control_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  alu_func,
  output logic        alu_flag_en,
  output logic        alu_b_sel,
  output logic [3:0]  alu_flags,
  input  logic [15:0] alu_q,
  input  logic [3:0]  alu_flag_q,
  input  logic        alu_b_out,
  output logic [2:0]  rf_ra,
  output logic [2:0]  rf_rb,
  output logic [2:0]  rf_wa,
  output logic        rf_we,
  output logic        rf_wsrc,
  output logic        op1_imm,
  output logic [15:0] imm,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [15:0] ld_data
);

  state_t      state, state_next;
  iclass_t     cls;
  logic [3:0]  flags;
  logic [15:0] addr_q;
  logic        flag_upd;
  logic        wr_class;

  instr_decoder u_dec (
    .opcode   (ir[OPC_MSB:OPC_LSB]),
    .i_bit    (ir[I_BIT]),
    .imm5     (ir[IMM_MSB:0]),
    .flag_en  (alu_flag_en),
    .flag_upd (flag_upd),
    .wr_class (wr_class),
    .op1_imm  (op1_imm),
    .imm      (imm),
    .iclass   (cls)
  );

  assign alu_func  = ir[OPC_MSB:OPC_LSB];
  assign alu_b_sel = ir[I_BIT];
  assign alu_flags = {flags[FLAG_C], flags[FLAG_N], flags[FLAG_V], flags[FLAG_Z]};
  assign rf_ra     = ir[RA_MSB:RA_LSB];
  assign rf_wa     = ir[RD_MSB:RD_LSB];
  assign rf_wsrc   = (cls == CLS_LD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      flags   <= '0;
      ld_data <= '0;
      addr_q  <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            ir <= mem_rdata;
            pc <= pc + 16'd1;
          end
        end
        S_EXEC_WAIT: begin
          if (flag_upd)
            flags <= alu_flag_q;
          // A taken branch overrides the PC+1 already applied at fetch.
          if (cls == CLS_BRANCH && alu_b_out)
            pc <= alu_q;
          if (cls == CLS_LD || cls == CLS_ST)
            addr_q <= alu_q;
        end
        S_MEM: begin
          if (mem_ack && cls == CLS_LD)
            ld_data <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = pc;
    rf_we      = 1'b0;
    rf_rb      = ir[RB_MSB:0];
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack)
          state_next = S_DECODE;
      end
      S_DECODE:    state_next = S_EXEC;
      S_EXEC:      state_next = S_EXEC_WAIT;
      S_EXEC_WAIT: begin
        case (cls)
          CLS_BRANCH, CLS_CMP: state_next = S_FETCH;
          CLS_LD, CLS_ST:      state_next = S_MEM;
          default:             state_next = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        mem_we   = (cls == CLS_ST);
        // Store data comes from rd, so port B reads rd during the access.
        if (cls == CLS_ST)
          rf_rb = ir[RD_MSB:RD_LSB];
        if (mem_ack)
          state_next = (cls == CLS_LD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        rf_we      = wr_class;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
    // Strobes are squashed while reset is held so an interrupted access
    // cannot issue a write on its way out.
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      rf_we   = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [3:0]  alu_func;
  logic        alu_flag_en;
  logic        alu_b_sel;
  logic [3:0]  alu_flags;
  logic [15:0] alu_q;
  logic [3:0]  alu_flag_q;
  logic        alu_b_out;
  logic [2:0]  rf_ra;
  logic [2:0]  rf_rb;
  logic [2:0]  rf_wa;
  logic        rf_we;
  logic        rf_wsrc;
  logic        op1_imm;
  logic [15:0] imm;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [15:0] ld_data;

  control_unit #(.RESET_PC(16'h0010)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .alu_func    (alu_func),
    .alu_flag_en (alu_flag_en),
    .alu_b_sel   (alu_b_sel),
    .alu_flags   (alu_flags),
    .alu_q       (alu_q),
    .alu_flag_q  (alu_flag_q),
    .alu_b_out   (alu_b_out),
    .rf_ra       (rf_ra),
    .rf_rb       (rf_rb),
    .rf_wa       (rf_wa),
    .rf_we       (rf_we),
    .rf_wsrc     (rf_wsrc),
    .op1_imm     (op1_imm),
    .imm         (imm),
    .pc          (pc),
    .ir          (ir),
    .ld_data     (ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] aq;
    logic [3:0]  fq;
    logic        bo;
    int          fw;
    int          mw;
    logic [15:0] rd;
    int          exp_cyc;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t        tbl[12];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] pc_m;
  logic [3:0]  flags_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one instruction starting at a negedge in FETCH and returns at the
  // negedge of the next FETCH. Memory answers after fw/mw wait cycles; the
  // ALU inputs are held for the whole instruction.
  task automatic run_instr(input logic [15:0] instr, input logic [15:0] aq, input logic [3:0] fq,
                           input logic bo, input int fw, input int mw, input logic [15:0] rd,
                           input bit noise, output int cyc);
    logic [3:0]  op;
    bit          ldst, br, wr, fl, fe, done;
    int          acks, need, req_cnt, we_cnt, we_cyc, exp_cyc, addr_bad;
    logic [15:0] pc_before, sx;
    logic [3:0]  flags_before;
    logic [2:0]  wa_s, rb_mem;
    logic        wsrc_s, we_mem;
    logic [9:0]  exec_ctrl;
    logic [22:0] exec_sel;

    op      = instr[15:12];
    ldst    = (op == 4'h8) || (op == 4'h9);
    br      = (op == 4'h0) || (op >= 4'hB && op <= 4'hE);
    wr      = (op >= 4'h1 && op <= 4'h8) || (op == 4'hA);
    fe      = (op >= 4'h1 && op <= 4'h7);
    fl      = fe || (op == 4'hF);
    exp_cyc = 4 + fw + (wr ? 1 : 0) + (ldst ? mw + 1 : 0);
    need    = ldst ? 2 : 1;
    sx      = {{11{instr[4]}}, instr[4:0]};
    pc_before    = pc_m;
    flags_before = flags_m;
    acks = 0; req_cnt = 0; we_cnt = 0; we_cyc = -1; addr_bad = 0; cyc = 0; done = 0;
    wa_s = 0; wsrc_s = 0; we_mem = 0; rb_mem = 0; exec_ctrl = 0; exec_sel = 0;
    alu_q = aq; alu_flag_q = fq; alu_b_out = bo;

    while (!done) begin
      if (cyc > 0 && acks == need && mem_req) begin
        done = 1;
      end else if (cyc >= 64) begin
        chk("timeout", 1, 0);
        done = 1;
      end else begin
        if (cyc == fw + 2) begin
          exec_ctrl = {alu_func, alu_flag_en, alu_b_sel, alu_flags};
          exec_sel  = {rf_ra, rf_rb, op1_imm, imm};
        end
        if (rf_we) begin
          we_cnt++;
          we_cyc = cyc;
          wa_s   = rf_wa;
          wsrc_s = rf_wsrc;
        end
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        if (mem_req) begin
          if (acks == 0 && (mem_addr !== pc_before || mem_we !== 1'b0)) addr_bad++;
          if (acks == 1) begin
            if (mem_addr !== aq) addr_bad++;
            we_mem = mem_we;
            rb_mem = rf_rb;
          end
          if (req_cnt == ((acks == 0) ? fw : mw)) begin
            mem_ack   = 1'b1;
            mem_rdata = (acks == 0) ? instr : rd;
            acks++;
            req_cnt = 0;
          end else begin
            req_cnt++;
          end
        end else if (noise) begin
          mem_ack = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    mem_ack = 1'b0;

    pc_m = pc_before + 16'd1;
    if (br && bo) pc_m = aq;
    if (fl) flags_m = fq;

    chk("cycles", cyc, exp_cyc);
    chk("mem_addr_hold", addr_bad, 0);
    chk("exec_ctrl", {22'd0, exec_ctrl}, {22'd0, op, fe, instr[5], flags_before});
    chk("exec_sel", {9'd0, exec_sel}, {9'd0, instr[8:6], instr[2:0], instr[5], sx});
    chk("rf_we_count", we_cnt, wr ? 1 : 0);
    if (wr) begin
      chk("wb_sel", {wa_s, wsrc_s}, {instr[11:9], op == 4'h8});
      chk("wb_cycle", we_cyc, exp_cyc - 1);
    end
    if (ldst) chk("mem_phase", {we_mem, rb_mem}, {op == 4'h9, (op == 4'h9) ? instr[11:9] : instr[2:0]});
    if (op == 4'h8) chk("ld_data", ld_data, rd);
    chk("pc", pc, pc_m);
    chk("flags", alu_flags, flags_m);
    chk("ir", ir, instr);
  endtask

  initial begin
    int  c;
    bit  found, fetched;
    logic [15:0] r_instr, r_aq;
    logic [3:0]  r_fq;
    logic        r_bo;

    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    alu_q = '0; alu_flag_q = '0; alu_b_out = 1'b0;

    //          instr     alu_q     fq    bo    fw mw rdata     cyc pc_after
    tbl[0]  = '{16'h1248, 16'h0005, 4'h0, 1'b0, 0, 0, 16'h0000, 5, 16'h0011};
    tbl[1]  = '{16'h8262, 16'h0100, 4'h0, 1'b0, 0, 2, 16'hBEEF, 8, 16'h0012};
    tbl[2]  = '{16'hB000, 16'h0040, 4'h0, 1'b1, 0, 0, 16'h0000, 4, 16'h0040};
    tbl[3]  = '{16'hB000, 16'h0077, 4'h0, 1'b0, 0, 0, 16'h0000, 4, 16'h0041};
    tbl[4]  = '{16'h9A62, 16'h0200, 4'h0, 1'b0, 0, 0, 16'h0000, 5, 16'h0042};
    tbl[5]  = '{16'hF040, 16'h0000, 4'hA, 1'b0, 0, 0, 16'h0000, 4, 16'h0043};
    tbl[6]  = '{16'hA3C5, 16'h1234, 4'hF, 1'b0, 0, 0, 16'h0000, 5, 16'h0044};
    tbl[7]  = '{16'h0020, 16'hFFFF, 4'h3, 1'b1, 3, 0, 16'h0000, 7, 16'hFFFF};
    tbl[8]  = '{16'h2251, 16'h0009, 4'h5, 1'b0, 1, 0, 16'h0000, 6, 16'h0000};
    tbl[9]  = '{16'h7FFF, 16'h0001, 4'h8, 1'b1, 0, 0, 16'h0000, 5, 16'h0001};
    tbl[10] = '{16'h8000, 16'h0010, 4'h0, 1'b0, 0, 0, 16'h1234, 6, 16'h0002};
    tbl[11] = '{16'h9000, 16'h0011, 4'h0, 1'b0, 0, 1, 16'h0000, 6, 16'h0003};

    repeat (3) @(negedge clk);
    chk("rst_strobes", {mem_req, mem_we, rf_we}, 3'b000);
    chk("rst_pc", pc, 16'h0010);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_flags", alu_flags, 4'h0);
    chk("rst_ld_data", ld_data, 16'h0000);
    rst = 1'b0;
    #1;
    chk("first_fetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0010});
    pc_m = 16'h0010;
    flags_m = 4'h0;

    for (int i = 0; i < 12; i++) begin
      run_instr(tbl[i].instr, tbl[i].aq, tbl[i].fq, tbl[i].bo, tbl[i].fw, tbl[i].mw,
                tbl[i].rd, 1'b0, c);
      chk("tbl_cycles", c, tbl[i].exp_cyc);
      chk("tbl_pc", pc, tbl[i].exp_pc);
    end

    // Reset lands in the MEM cycle of a store, with ack in that same cycle.
    alu_q = 16'h0300; alu_flag_q = 4'hF; alu_b_out = 1'b0;
    found = 0; fetched = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      mem_ack = 1'b0;
      if (mem_we) begin
        found = 1;
      end else begin
        if (mem_req && !fetched) begin
          mem_ack = 1'b1;
          mem_rdata = 16'h9E00;
          fetched = 1;
        end
        @(posedge clk);
        @(negedge clk);
      end
    end
    chk("st_reached_mem", {31'd0, found}, 1);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h0;
    #1;
    chk("rst_drops_req", {mem_req, mem_we}, 2'b00);
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0; rst = 1'b0;
    #1;
    chk("rst_st_strobes", {mem_req, mem_we, rf_we}, 3'b100);
    chk("rst_st_addr", mem_addr, 16'h0010);
    chk("rst_st_pc", pc, 16'h0010);
    chk("rst_st_state", {ir, alu_flags}, 20'h0);
    pc_m = 16'h0010;
    flags_m = 4'h0;

    for (int i = 0; i < 40; i++) begin
      r_instr = 16'($urandom);
      r_aq    = 16'($urandom);
      r_fq    = 4'($urandom);
      r_bo    = 1'($urandom_range(0, 1));
      run_instr(r_instr, r_aq, r_fq, r_bo, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                16'($urandom), 1'b1, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
